// File: rtl/e203_ifu_instr_align_pkg.sv
// Shared definitions for the fetch-side instruction aligner.
//   E203_INSTR_SIZE : instruction / fetch word width
//   ALN_*           : leftover-halfword state encodings (2-bit)
//   is_rv32()       : halfword opcode-length test
package e203_ifu_instr_align_pkg;

  localparam int E203_INSTR_SIZE = 32;

  localparam logic [1:0] ALN_EMPTY = 2'd0;  // no leftover halfword
  localparam logic [1:0] ALN_LO16  = 2'd1;  // leftover is a whole 16-bit instr
  localparam logic [1:0] ALN_LO32  = 2'd2;  // leftover is low half of a 32-bit instr

  function automatic logic is_rv32(input logic [15:0] hw);
    return hw[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/e203_ifu_instr_align_if.sv
// Handshake bundle between the fetch-response path, the aligner and decode.
//   rsp_* : fetch word channel (valid/ready, word, pc bit 1, bus error)
//   ir_*  : aligned instruction channel (valid/ready, instr, rv32, error)
// modport slave  : the aligner side (consumes rsp, produces ir)
// modport master : the environment side (produces rsp, consumes ir)
interface e203_ifu_instr_align_if;
  import e203_ifu_instr_align_pkg::*;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [E203_INSTR_SIZE-1:0] rsp_instr;
  logic                       rsp_pc1;
  logic                       rsp_err;

  logic                       ir_valid;
  logic                       ir_ready;
  logic [E203_INSTR_SIZE-1:0] ir_instr;
  logic                       ir_rv32;
  logic                       ir_err;

  modport slave (
    input  rsp_valid, rsp_instr, rsp_pc1, rsp_err, ir_ready,
    output rsp_ready, ir_valid, ir_instr, ir_rv32, ir_err
  );

  modport master (
    output rsp_valid, rsp_instr, rsp_pc1, rsp_err, ir_ready,
    input  rsp_ready, ir_valid, ir_instr, ir_rv32, ir_err
  );

endinterface

// File: rtl/e203_ifu_align_outreg.sv
// Single valid/ready output slot holding instr/rv32/err.
//   clk, rst_n   : clock, async active-low reset (clears slot and data)
//   flush        : drops the slot on the next edge regardless of out_ready
//   load, d_*    : new slot contents; caller only loads when out_free && !flush
//   out_ready    : downstream accept
//   out_valid    : slot occupied
//   out_free     : slot can take a new entry this cycle
//   instr/rv32/err : registered slot contents, held while stalled
module e203_ifu_align_outreg
  import e203_ifu_instr_align_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       load,
  input  logic [E203_INSTR_SIZE-1:0] d_instr,
  input  logic                       d_rv32,
  input  logic                       d_err,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       out_free,
  output logic [E203_INSTR_SIZE-1:0] instr,
  output logic                       rv32,
  output logic                       err
);

  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= '0;
      rv32      <= 1'b0;
      err       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      instr     <= d_instr;
      rv32      <= d_rv32;
      err       <= d_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/e203_ifu_instr_align.sv
// Fetch-side instruction aligner: turns 32-bit aligned fetch words into
// whole 16/32-bit instructions, one registered instruction per handshake.
//   clk, rst_n : clock, async active-low reset
//   flush      : redirect pulse; clears leftover and output slot, blocks rsp
//   bus        : rsp_* fetch channel in, ir_* instruction channel out
// Build option E203_IFU_ALIGN_RVC_EN: when defined, full halfword alignment
// with a one-halfword leftover register; when undefined every fetch word is
// passed through as one 32-bit instruction and rsp_pc1 is ignored.
module e203_ifu_instr_align
  import e203_ifu_instr_align_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  e203_ifu_instr_align_if.slave         bus
);

  logic                       out_free;
  logic                       go;
  logic                       load;
  logic [E203_INSTR_SIZE-1:0] d_instr;
  logic                       d_rv32;
  logic                       d_err;

  assign go = out_free && !flush;

`ifdef E203_IFU_ALIGN_RVC_EN
  logic [1:0]  state, nxt_state;
  logic [15:0] left, nxt_left;
  logic [15:0] lo, hi;

  assign lo = bus.rsp_instr[15:0];
  assign hi = bus.rsp_instr[31:16];

  // A LO16 leftover drains on its own cycle, so no word is taken then.
  assign bus.rsp_ready = go && (state != ALN_LO16);

  always_comb begin
    load      = 1'b0;
    d_instr   = '0;
    d_rv32    = 1'b0;
    d_err     = 1'b0;
    nxt_state = state;
    nxt_left  = left;
    if (flush) begin
      nxt_state = ALN_EMPTY;
    end else if (go) begin
      if (state == ALN_LO16) begin
        load      = 1'b1;
        d_instr   = {16'h0, left};
        nxt_state = ALN_EMPTY;
      end else if (bus.rsp_valid) begin
        if (bus.rsp_err) begin
          // Error slot replaces whatever was in flight; leftover is dropped.
          load      = 1'b1;
          d_err     = 1'b1;
          nxt_state = ALN_EMPTY;
        end else if (state == ALN_LO32) begin
          // Sequential fetch after a straddle is word-aligned: pc1 ignored.
          load      = 1'b1;
          d_instr   = {lo, left};
          d_rv32    = 1'b1;
          nxt_left  = hi;
          nxt_state = is_rv32(hi) ? ALN_LO32 : ALN_LO16;
        end else if (!bus.rsp_pc1) begin
          load = 1'b1;
          if (is_rv32(lo)) begin
            d_instr = bus.rsp_instr;
            d_rv32  = 1'b1;
          end else begin
            d_instr   = {16'h0, lo};
            nxt_left  = hi;
            nxt_state = is_rv32(hi) ? ALN_LO32 : ALN_LO16;
          end
        end else if (is_rv32(hi)) begin
          // Halfword redirect onto a 32-bit instr: park it, emit nothing.
          nxt_left  = hi;
          nxt_state = ALN_LO32;
        end else begin
          load    = 1'b1;
          d_instr = {16'h0, hi};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALN_EMPTY;
      left  <= '0;
    end else begin
      state <= nxt_state;
      left  <= nxt_left;
    end
  end
`else
  assign bus.rsp_ready = go;
  assign load          = bus.rsp_ready && bus.rsp_valid;
  assign d_instr       = bus.rsp_err ? '0 : bus.rsp_instr;
  assign d_rv32        = 1'b1;
  assign d_err         = bus.rsp_err;
`endif

  e203_ifu_align_outreg u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load),
    .d_instr   (d_instr),
    .d_rv32    (d_rv32),
    .d_err     (d_err),
    .out_ready (bus.ir_ready),
    .out_valid (bus.ir_valid),
    .out_free  (out_free),
    .instr     (bus.ir_instr),
    .rv32      (bus.ir_rv32),
    .err       (bus.ir_err)
  );

endmodule

// File: tb/tb_e203_ifu_instr_align.sv
// Directed self-checking bench for e203_ifu_instr_align. Covers both builds
// of E203_IFU_ALIGN_RVC_EN; halfword alignment scenarios only exist when the
// macro is defined.
module tb_e203_ifu_instr_align;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_chk;
  int   n_fail;

  e203_ifu_instr_align_if bus();

  e203_ifu_instr_align dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input logic v, input logic [31:0] w, input logic p1,
                         input logic e);
    bus.rsp_valid = v;
    bus.rsp_instr = w;
    bus.rsp_pc1   = p1;
    bus.rsp_err   = e;
  endtask

  task automatic test_reset();
    n_chk++;
    if (bus.ir_valid !== 1'b0 || bus.ir_instr !== 32'h0 ||
        bus.ir_rv32 !== 1'b0 || bus.ir_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b i=%h r=%b e=%b, want 0 00000000 0 0",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32, bus.ir_err);
    end
    #1;
    n_chk++;
    if (bus.rsp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rsp_ready: got %b want 1", bus.rsp_ready);
    end
  endtask

  task automatic test_rv32_stream();
    bus.ir_ready = 1'b1;
    set_rsp(1'b1, 32'h00A50513, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00A50513 || bus.ir_rv32 !== 1'b1) begin
      n_fail++;
      $display("FAIL rv32_w0: got v=%b i=%h r=%b, want 1 00a50513 1",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    set_rsp(1'b1, 32'h00B58593, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00B58593 || bus.ir_rv32 !== 1'b1) begin
      n_fail++;
      $display("FAIL rv32_w1: got v=%b i=%h r=%b, want 1 00b58593 1",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rv32_drain: got v=%b want 0", bus.ir_valid);
    end
  endtask

`ifdef E203_IFU_ALIGN_RVC_EN
  task automatic test_two16();
    bus.ir_ready = 1'b1;
    set_rsp(1'b1, 32'h45050001, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00000001 || bus.ir_rv32 !== 1'b0) begin
      n_fail++;
      $display("FAIL two16_a: got v=%b i=%h r=%b, want 1 00000001 0",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (bus.rsp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL two16_rsp_ready: got %b want 0", bus.rsp_ready);
    end
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00004505 || bus.ir_rv32 !== 1'b0) begin
      n_fail++;
      $display("FAIL two16_b: got v=%b i=%h r=%b, want 1 00004505 0",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL two16_idle: got v=%b want 0", bus.ir_valid);
    end
  endtask

  task automatic test_straddle();
    bus.ir_ready = 1'b1;
    set_rsp(1'b1, 32'h05130001, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00000001 || bus.ir_rv32 !== 1'b0) begin
      n_fail++;
      $display("FAIL straddle_a: got v=%b i=%h r=%b, want 1 00000001 0",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    set_rsp(1'b1, 32'h450500A5, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00A50513 || bus.ir_rv32 !== 1'b1) begin
      n_fail++;
      $display("FAIL straddle_b: got v=%b i=%h r=%b, want 1 00a50513 1",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00004505 || bus.ir_rv32 !== 1'b0) begin
      n_fail++;
      $display("FAIL straddle_c: got v=%b i=%h r=%b, want 1 00004505 0",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL straddle_idle: got v=%b want 0", bus.ir_valid);
    end
  endtask

  task automatic test_redirect();
    bus.ir_ready = 1'b1;
    set_rsp(1'b1, 32'h05130000, 1'b1, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_noslot: got v=%b want 0", bus.ir_valid);
    end
    set_rsp(1'b1, 32'h000000A5, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00A50513 || bus.ir_rv32 !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_slot: got v=%b i=%h r=%b, want 1 00a50513 1",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    // Upper 0x0000 is now a LO16 leftover; flush it away.
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_flush: got v=%b want 0", bus.ir_valid);
    end
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_noleft: got v=%b want 0", bus.ir_valid);
    end
  endtask

  task automatic test_flush_lo32();
    bus.ir_ready = 1'b1;
    set_rsp(1'b1, 32'h05130000, 1'b1, 1'b0);
    cyc();
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_lo32_clear: got v=%b want 0", bus.ir_valid);
    end
    set_rsp(1'b1, 32'h00A50513, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00A50513 || bus.ir_rv32 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_lo32_fresh: got v=%b i=%h r=%b, want 1 00a50513 1",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
  endtask
`endif

  task automatic test_backpressure();
    bus.ir_ready = 1'b0;
    set_rsp(1'b1, 32'h00A50513, 1'b0, 1'b0);
    cyc();
    set_rsp(1'b1, 32'h00B58593, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (bus.rsp_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_rsp_ready[%0d]: got %b want 0", i, bus.rsp_ready);
      end
      n_chk++;
      if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00A50513) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b i=%h, want 1 00a50513",
                 i, bus.ir_valid, bus.ir_instr);
      end
      cyc();
    end
    bus.ir_ready = 1'b1;
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00B58593) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b i=%h, want 1 00b58593",
               bus.ir_valid, bus.ir_instr);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic test_flush_stall();
    bus.ir_ready = 1'b0;
    set_rsp(1'b1, 32'h00A50513, 1'b0, 1'b0);
    cyc();
    set_rsp(1'b1, 32'h00B58593, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    n_chk++;
    if (bus.rsp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_rsp_ready: got %b want 0", bus.rsp_ready);
    end
    cyc();
    flush = 1'b0;
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall_clear: got v=%b want 0", bus.ir_valid);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    bus.ir_ready = 1'b1;
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_noload: got v=%b want 0", bus.ir_valid);
    end
  endtask

  task automatic test_err();
    logic exp_rv32;
    bus.ir_ready = 1'b1;
`ifdef E203_IFU_ALIGN_RVC_EN
    exp_rv32 = 1'b0;
    set_rsp(1'b1, 32'h05130000, 1'b1, 1'b0);
    cyc();
`else
    exp_rv32 = 1'b1;
`endif
    set_rsp(1'b1, 32'h12345678, 1'b0, 1'b1);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h0 || bus.ir_err !== 1'b1 ||
        bus.ir_rv32 !== exp_rv32) begin
      n_fail++;
      $display("FAIL err_slot: got v=%b i=%h e=%b r=%b, want 1 00000000 1 %b",
               bus.ir_valid, bus.ir_instr, bus.ir_err, bus.ir_rv32, exp_rv32);
    end
    set_rsp(1'b1, 32'h00B58593, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00B58593 || bus.ir_err !== 1'b0 ||
        bus.ir_rv32 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_after: got v=%b i=%h e=%b r=%b, want 1 00b58593 0 1",
               bus.ir_valid, bus.ir_instr, bus.ir_err, bus.ir_rv32);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.ir_ready = 1'b1;
`ifdef E203_IFU_ALIGN_RVC_EN
    set_rsp(1'b1, 32'h05130001, 1'b0, 1'b0);  // leaves a LO32 leftover
`else
    set_rsp(1'b1, 32'h00A50513, 1'b0, 1'b0);
`endif
    cyc();
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    bus.ir_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.ir_valid !== 1'b0 || bus.ir_instr !== 32'h0 ||
        bus.ir_rv32 !== 1'b0 || bus.ir_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b i=%h r=%b e=%b, want 0 00000000 0 0",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32, bus.ir_err);
    end
    rst_n = 1'b1;
    bus.ir_ready = 1'b1;
    set_rsp(1'b1, 32'h00A50513, 1'b0, 1'b0);
    cyc();
    n_chk++;
    if (bus.ir_valid !== 1'b1 || bus.ir_instr !== 32'h00A50513 || bus.ir_rv32 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got v=%b i=%h r=%b, want 1 00a50513 1",
               bus.ir_valid, bus.ir_instr, bus.ir_rv32);
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.ir_ready = 1'b0;
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    test_reset();
    test_rv32_stream();
`ifdef E203_IFU_ALIGN_RVC_EN
    test_two16();
    test_straddle();
    test_redirect();
    test_flush_lo32();
`endif
    test_backpressure();
    test_flush_stall();
    test_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
